sevseg_scan_driver: RTL

Upstream feeder for the seven-segment control stage.
- Accepts a binary amount (e.g. an ATM balance or withdrawal amount) on a load strobe.
- Converts the amount to packed BCD with an iterative shift-add-3 (double-dabble) engine, one shift per clock.
- Time-multiplexes the resulting digits onto LED_Select / LED_BCD, which feed the display control stage directly.
- Runs on the 1 kHz display refresh clock.

---
 rtl/sevseg_scan_driver_if.sv | 23 ++
 rtl/sevseg_scan_driver.sv | 117 +++++++++++
 2 files changed

// File: rtl/sevseg_scan_driver_if.sv
// Bus between the amount source and the seven-segment scan driver:
// amount/load handshake in, scanned digit select and code out.
interface sevseg_scan_driver_if #(
  parameter int unsigned WIDTH = 27
);
  logic [WIDTH-1:0] value;
  logic             load;
  logic             blank_leading;
  logic             busy;
  logic             overflow;
  logic [3:0]       LED_Select;
  logic [3:0]       LED_BCD;

  modport master (
    output value, load, blank_leading,
    input  busy, overflow, LED_Select, LED_BCD
  );

  modport slave (
    input  value, load, blank_leading,
    output busy, overflow, LED_Select, LED_BCD
  );
endinterface

// File: rtl/sevseg_scan_driver.sv
// Binary-to-BCD (shift-add-3, one shift per clock) feeding a free-running
// digit scanner; the shown amount only changes when a conversion completes.
module sevseg_scan_driver #(
  parameter int unsigned WIDTH  = 27,
  parameter int unsigned DIGITS = 8
) (
  input logic                clk_1ms,
  input logic                rst,
  sevseg_scan_driver_if.slave bus
);

  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
  localparam int unsigned SCAN_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

  localparam longint unsigned MAX_VAL = pow10(DIGITS) - 64'd1;

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t            state;
  logic [BCD_W-1:0]  bcd, bcd_adj, bcd_shift;
  logic [BCD_W-1:0]  disp, disp_nxt;
  logic [WIDTH-1:0]  bin, bin_shift;
  logic [CNT_W-1:0]  cnt;
  logic              ovf_pending, ovf_nxt, done;
  logic [SCAN_W-1:0] scan, scan_nxt;
  logic [3:0]        digit_sel, led_nxt;
  logic              hi_zero;

  // One double-dabble step: add 3 to every nibble >= 5, then shift left.
  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    {bcd_shift, bin_shift} = {bcd_adj, bin} << 1;
  end

  // Display contents as of the next edge, so a finished conversion reaches
  // the scan output in the same slot that busy falls.
  always_comb begin
    done     = (state == CONVERT) && (cnt == CNT_W'(1));
    disp_nxt = disp;
    ovf_nxt  = bus.overflow;
    if (done) begin
      ovf_nxt  = ovf_pending;
      disp_nxt = ovf_pending ? {DIGITS{4'hE}} : bcd_shift;
    end
  end

  always_comb begin
    scan_nxt  = (scan == SCAN_W'(DIGITS - 1)) ? '0 : scan + SCAN_W'(1);
    digit_sel = 4'd0;
    hi_zero   = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scan_nxt == SCAN_W'(i)) digit_sel = disp_nxt[4*i +: 4];
      if ((i >= 32'(scan_nxt)) && (disp_nxt[4*i +: 4] != 4'd0)) hi_zero = 1'b0;
    end
    // Digit 0 and the error pattern are never blanked.
    if (bus.blank_leading && (scan_nxt != '0) && !ovf_nxt && hi_zero)
      led_nxt = 4'hF;
    else
      led_nxt = digit_sel;
  end

  always_ff @(posedge clk_1ms) begin
    if (rst) begin
      state          <= IDLE;
      bcd            <= '0;
      bin            <= '0;
      cnt            <= '0;
      ovf_pending    <= 1'b0;
      disp           <= '0;
      scan           <= '0;
      bus.busy       <= 1'b0;
      bus.overflow   <= 1'b0;
      bus.LED_Select <= 4'd0;
      bus.LED_BCD    <= 4'd0;
    end else begin
      scan           <= scan_nxt;
      bus.LED_Select <= 4'(scan_nxt);
      bus.LED_BCD    <= led_nxt;
      disp           <= disp_nxt;
      bus.overflow   <= ovf_nxt;
      case (state)
        IDLE: begin
          if (bus.load) begin
            bin         <= bus.value;
            bcd         <= '0;
            cnt         <= CNT_W'(WIDTH);
            ovf_pending <= 64'(bus.value) > MAX_VAL;
            bus.busy    <= 1'b1;
            state       <= CONVERT;
          end
        end
        CONVERT: begin
          bcd <= bcd_shift;
          bin <= bin_shift;
          cnt <= cnt - CNT_W'(1);
          if (done) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
